// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, play-state encoding and track codes
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CLK_HZ      = 50_000_000;
  localparam int MS_TICK_DIV = CLK_HZ / 1000;

  localparam logic [1:0] TRK_NONE = 2'd0;
  localparam logic [1:0] TRK_UP   = 2'd1;
  localparam logic [1:0] TRK_DN   = 2'd2;
  localparam logic [1:0] TRK_BOTH = 2'd3;

  function automatic logic [1:0] track_code(input logic t1, input logic t2);
    case ({t2, t1})
      2'b01:   return TRK_UP;
      2'b10:   return TRK_DN;
      2'b11:   return TRK_BOTH;
      default: return TRK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with sync clear, 1-cycle tick on wrap
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_tone_player.sv
// rtl/note_tone_player.sv - plays spawned notes as a timed square wave on the buzzer
// Optional decay envelope (8-cycle PWM, duty 7/5/3/1 per quarter) with NOTE_TONE_DECAY_EN.
module note_tone_player
  import game_pkg::*;
#(
  parameter int TICK_DIV = MS_TICK_DIV,
  parameter int NOTE_MS  = 400,
  parameter int PITCH_W  = 32,
  parameter int MIN_HALF = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_note_t1,
  input  logic               i_note_t2,
  input  logic [PITCH_W-1:0] i_pitch,
  input  logic               i_game_end,
  input  logic               i_mute,
  output logic               o_buzzer,
  output logic               o_playing,
  output logic [1:0]         o_track,
  output logic               o_done
);

  localparam int MS_W = $clog2(NOTE_MS + 1);
  localparam logic [MS_W-1:0]    MS_LAST = MS_W'(NOTE_MS - 1);
  localparam logic [PITCH_W-1:0] MIN_P   = PITCH_W'(MIN_HALF);

  state_e             state_q, state_d;
  logic [PITCH_W-1:0] half_lat_q, half_lat_d;
  logic [PITCH_W-1:0] half_cnt_q, half_cnt_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [1:0]         track_q, track_d;
  logic               tone_q, tone_d;
  logic               buz_q, buz_d;
  logic               trig, valid, cap, ms_tick, gate;

  assign trig  = i_note_t1 | i_note_t2;
  assign valid = trig & (i_pitch >= MIN_P);
  // Game end outranks a capture, and DONE swallows every trigger.
  assign cap   = valid & ~i_game_end & (state_q != ST_DONE);

  ms_tick_gen #(.DIV(TICK_DIV)) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cap),
    .en_i   (state_q == ST_PLAY),
    .tick_o (ms_tick)
  );

  always_comb begin
    state_d    = state_q;
    half_lat_d = half_lat_q;
    half_cnt_d = half_cnt_q;
    ms_cnt_d   = ms_cnt_q;
    track_d    = track_q;
    tone_d     = tone_q;
    if (i_game_end) begin
      state_d = ST_DONE;
      tone_d  = 1'b0;
      track_d = TRK_NONE;
    end else if (cap) begin
      state_d    = ST_PLAY;
      half_lat_d = i_pitch;
      track_d    = track_code(i_note_t1, i_note_t2);
      half_cnt_d = '0;
      ms_cnt_d   = '0;
      tone_d     = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (half_cnt_q == half_lat_q - 1'b1) begin
        half_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
      end
      if (ms_tick) begin
        if (ms_cnt_q == MS_LAST) begin
          state_d    = ST_IDLE;
          tone_d     = 1'b0;
          track_d    = TRK_NONE;
          half_cnt_d = '0;
          ms_cnt_d   = '0;
        end else begin
          ms_cnt_d = ms_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef NOTE_TONE_DECAY_EN
  logic [2:0] pwm_q, pwm_d, level;

  always_comb begin
    pwm_d = cap ? 3'd0 : pwm_q + 3'd1;
    if (int'(ms_cnt_d) * 4 < NOTE_MS)          level = 3'd7;
    else if (int'(ms_cnt_d) * 4 < 2 * NOTE_MS) level = 3'd5;
    else if (int'(ms_cnt_d) * 4 < 3 * NOTE_MS) level = 3'd3;
    else                                       level = 3'd1;
    gate = (pwm_d < level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 3'd0;
    else     pwm_q <= pwm_d;
  end
`else
  assign gate = 1'b1;
`endif

  // Buzzer follows the next tone value so it rises on the capture edge itself.
  assign buz_d = tone_d & ~i_mute & gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      half_lat_q <= '0;
      half_cnt_q <= '0;
      ms_cnt_q   <= '0;
      track_q    <= TRK_NONE;
      tone_q     <= 1'b0;
      buz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_lat_q <= half_lat_d;
      half_cnt_q <= half_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      track_q    <= track_d;
      tone_q     <= tone_d;
      buz_q      <= buz_d;
    end
  end

  assign o_buzzer  = buz_q;
  assign o_playing = (state_q == ST_PLAY);
  assign o_done    = (state_q == ST_DONE);
  assign o_track   = track_q;

endmodule

// File: tb/tb_note_tone_player.sv
// tb/tb_note_tone_player.sv - directed vector bench for note_tone_player (TICK_DIV=10, NOTE_MS=3, MIN_HALF=2)
module tb_note_tone_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t1 = 1'b0, t2 = 1'b0, ge = 1'b0, mute = 1'b0;
  logic [31:0] pitch = '0;
  logic        bz, pl, dn;
  logic [1:0]  trk;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  note_tone_player #(
    .TICK_DIV (10),
    .NOTE_MS  (3),
    .PITCH_W  (32),
    .MIN_HALF (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_note_t1  (t1),
    .i_note_t2  (t2),
    .i_pitch    (pitch),
    .i_game_end (ge),
    .i_mute     (mute),
    .o_buzzer   (bz),
    .o_playing  (pl),
    .o_track    (trk),
    .o_done     (dn)
  );

  typedef struct {
    logic        t1, t2;
    logic [31:0] pitch;
    logic        ge;
    int          waitn;
    logic        bz, pl;
    logic [1:0]  trk;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a1, input logic a2, input logic [31:0] p, input logic g,
                     input int w, input logic ebz, input logic epl, input logic [1:0] etrk,
                     input logic edn);
    vec_t v;
    v.t1 = a1; v.t2 = a2; v.pitch = p; v.ge = g; v.waitn = w;
    v.bz = ebz; v.pl = epl; v.trk = etrk; v.dn = edn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ebz, input logic epl,
                         input logic [1:0] etrk, input logic edn);
    chk({nm, ".buzzer"},  32'(bz),  32'(ebz));
    chk({nm, ".playing"}, 32'(pl),  32'(epl));
    chk({nm, ".track"},   32'(trk), 32'(etrk));
    chk({nm, ".done"},    32'(dn),  32'(edn));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic eb;
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 0, 2'd0, 0);
    rst = 1'b0;
    step();
    chk_out("idle", 0, 0, 2'd0, 0);

    // pitch 5 on t1: high at capture, toggle every 5, end at 30
    add(1, 0, 5, 0,  1, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  4, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 1, 2'd1, 0);
    add(0, 0, 0, 0,  5, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0, 14, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  5, 0, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0);
    // t2 pitch 4, retriggered by t1 pitch 7 twelve cycles later
    add(0, 1, 4, 0,  1, 1, 1, 2'd2, 0);
    add(0, 0, 0, 0,  3, 1, 1, 2'd2, 0);
    add(0, 0, 0, 0,  1, 0, 1, 2'd2, 0);
    add(0, 0, 0, 0,  4, 1, 1, 2'd2, 0);
    add(0, 0, 0, 0,  3, 1, 1, 2'd2, 0);
    add(1, 0, 7, 0,  1, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  6, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 1, 2'd1, 0);
    add(0, 0, 0, 0,  7, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  4, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0, 11, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0);
    // pitch 0 in IDLE is ignored
    add(0, 1, 0, 0,  1, 0, 0, 2'd0, 0);
    // both tracks pitch 3, then an invalid pitch-1 pulse mid-note
    add(1, 1, 3, 0,  1, 1, 1, 2'd3, 0);
    add(0, 0, 0, 0,  2, 1, 1, 2'd3, 0);
    add(1, 0, 1, 0,  1, 0, 1, 2'd3, 0);
    add(0, 0, 0, 0,  2, 0, 1, 2'd3, 0);
    add(0, 0, 0, 0,  1, 1, 1, 2'd3, 0);
    add(0, 0, 0, 0, 23, 0, 1, 2'd3, 0);
    add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0);
    // pitch exactly MIN_HALF is accepted
    add(1, 0, 2, 0,  1, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 1, 2'd1, 0);
    add(0, 0, 0, 0,  2, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0, 25, 1, 1, 2'd1, 0);
    add(0, 0, 0, 0,  1, 0, 0, 2'd0, 0);
    // game end beats a simultaneous trigger; DONE ignores later pulses
    add(1, 0, 5, 0,  1, 1, 1, 2'd1, 0);
    add(1, 0, 5, 1,  1, 0, 0, 2'd0, 1);
    add(1, 1, 5, 0,  1, 0, 0, 2'd0, 1);
    add(0, 0, 0, 0,  3, 0, 0, 2'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      t1 = vecs[i].t1; t2 = vecs[i].t2; pitch = vecs[i].pitch; ge = vecs[i].ge;
      for (int k = 0; k < vecs[i].waitn; k++) begin
        step();
        if (k == 0) begin
          t1 = 1'b0; t2 = 1'b0; pitch = '0; ge = 1'b0;
        end
      end
      chk_out($sformatf("vec%0d", i), vecs[i].bz, vecs[i].pl, vecs[i].trk, vecs[i].dn);
    end

    #2 rst = 1'b1;
    #1 chk_out("rst_from_done", 0, 0, 2'd0, 0);
    @(negedge clk) rst = 1'b0;
    step();
    chk_out("idle_after_rst", 0, 0, 2'd0, 0);

    // mute over edges 5..15 of a pitch-5 note
    t1 = 1'b1; pitch = 5;
    step();
    t1 = 1'b0; pitch = '0;
    chk_out("mute_cap", 1, 1, 2'd1, 0);
    for (int k = 1; k <= 30; k++) begin
      mute = (k >= 5 && k <= 15);
      step();
      eb = (k < 30) && (((k / 5) % 2) == 0) && !mute;
      chk_out($sformatf("mute_e%0d", k), eb, (k < 30), (k < 30) ? 2'd1 : 2'd0, 0);
    end
    mute = 1'b0;

    // asynchronous reset in the middle of a note
    t1 = 1'b1; pitch = 5;
    step();
    t1 = 1'b0; pitch = '0;
    repeat (11) step();
    chk_out("pre_rst", 1, 1, 2'd1, 0);
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", 0, 0, 2'd0, 0);
    @(negedge clk) rst = 1'b0;
    step();
    chk_out("post_rst", 0, 0, 2'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
